// File: rtl/regfile_wr_sched.sv
// Write-port scheduler: two writeback requesters share one bank write port.
// Define WRSCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module regfile_wr_sched #(
  parameter  int DW   = 9,
  parameter  int AW   = 3,
  localparam int NREG = 1 << AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            req0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   data0,
  input  logic            req1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   data1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            regWrite,
  output logic [NREG-1:0] decOut,
  output logic [DW-1:0]   writeData
);

  logic            w_gnt0;
  logic            w_gnt1;
  logic            r_reg_write;
  logic [NREG-1:0] r_dec_out;
  logic [DW-1:0]   r_write_data;

`ifdef WRSCHED_RR_EN
  logic r_prio;

  // Priority only matters under contention; an idle rival never blocks a grant.
  assign w_gnt0 = req0 & ~hold & ~reset & (~r_prio | ~req1);
  assign w_gnt1 = req1 & ~hold & ~reset & ( r_prio | ~req0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (w_gnt0) begin
      r_prio <= 1'b1;
    end else if (w_gnt1) begin
      r_prio <= 1'b0;
    end
  end
`else
  assign w_gnt0 = req0 & ~hold & ~reset;
  assign w_gnt1 = req1 & ~req0 & ~hold & ~reset;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_dec_out    <= '0;
      r_write_data <= '0;
    end else if (w_gnt0) begin
      r_reg_write  <= 1'b1;
      r_dec_out    <= NREG'(1) << addr0;
      r_write_data <= data0;
    end else if (w_gnt1) begin
      r_reg_write  <= 1'b1;
      r_dec_out    <= NREG'(1) << addr1;
      r_write_data <= data1;
    end else begin
      r_reg_write  <= 1'b0;
      r_dec_out    <= '0;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign regWrite  = r_reg_write;
  assign decOut    = r_dec_out;
  assign writeData = r_write_data;

endmodule

// File: doc/regfile_wr_sched.md
# regfile_wr_sched

Write-port scheduler for the 9-bit register bank. Two writeback requesters share the single bank write port: requester 0 is the ALU writeback and requester 1 is the load writeback. The block arbitrates between them round-robin and accepts requests through a req/gnt handshake. It drives the bank's registered write controls: `regWrite`, the one-hot per-register enable `decOut` (one bit per register's `decOut1b`), and `writeData`.

## Interface
- `DW`, 9, data width of each register.
- `AW`, 3, register address width.
- `NREG`, 1<<AW, number of registers in the bank (derived, not overridden).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `hold`  in  1  bank busy; while high, no grants are issued.
- `req0`  in  1  requester 0 write request.
- `addr0`  in  AW  requester 0 target register.
- `data0`  in  DW  requester 0 write data.
- `req1`  in  1  requester 1 write request.
- `addr1`  in  AW  requester 1 target register.
- `data1`  in  DW  requester 1 write data.
- `gnt0`  out  1  requester 0 accepted this cycle (combinational).
- `gnt1`  out  1  requester 1 accepted this cycle (combinational).
- `regWrite`  out  1  registered bank write strobe.
- `decOut`  out  NREG  registered one-hot register select.
- `writeData`  out  DW  registered write data.

## Operation
- **Handshake:**
  - A requester raises `reqK` with `addrK`/`dataK` stable.
  - The request is accepted at the rising edge where `reqK & gntK` holds.
  - The requester holds req/addr/data until that edge, then may drop `reqK` or present the next request.
- **Grant logic:**
  - `gntK = reqK & ~hold & (priority to K, or other requester idle)`.
  - At most one grant is high per cycle.
- **Priority pointer:**
  - The pointer `prio` is 1 bit; reset value 0, so requester 0 is favoured first.
  - On any accepted grant to K, `prio` becomes the other requester.
  - With no grant, `prio` holds.
- **Write stage:**
  - On an accepted grant from K: `regWrite<=1`, `decOut<=1<<addrK`, `writeData<=dataK`.
  - With no grant: `regWrite<=0`, `decOut<=0`, `writeData` holds its previous value.
- **Same-address requests:** both requests are written serially in grant order, and the later write wins in the bank. No merging.
- **Reset values:**
  - Outputs: `regWrite=0`, `decOut=0`, `writeData=0`.
  - State: `prio=0`.
  - `gnt0`/`gnt1` are 0 while `reset` is high.
- **Reset mid-operation:** a request accepted at the edge where reset is sampled is dropped and no write is issued. The requester sees no completion and must re-request.

## Timing
- Latency: accept at edge N → `regWrite`, `decOut` and `writeData` valid for exactly cycle N+1 (one-cycle pulse per write).
- Throughput: one write per cycle. Back-to-back grants produce a continuous `regWrite` with `decOut` changing per cycle.
- Under full contention, grants alternate 0,1,0,1… One requester waits at most 1 cycle while the other is being served.
- `hold` is sampled combinationally.
  - Asserting `hold` in cycle N suppresses the grant at edge N.
  - A write already registered at edge N-1 still appears in cycle N.
- `decOut` is always either all zero or exactly one-hot. It is nonzero only when `regWrite=1`.

## Configuration
- `WRSCHED_RR_EN` defined:
  - round-robin arbitration as described above.
- Macro not defined:
  - Fixed priority, requester 0 always wins.
  - `prio` is not implemented.
  - `gnt1 = req1 & ~req0 & ~hold`.
  - Requester 1 can starve under continuous `req0`.

## Test plan
- Reset then idle: `reset=1` for 2 cycles, then no requests → `regWrite=0`, `decOut=8'h00`, `writeData=9'h000` every cycle.
- Single write: `req0=1`, `addr0=3`, `data0=9'h1A5` for one cycle → `gnt0=1` that cycle; next cycle `regWrite=1`, `decOut=8'h08`, `writeData=9'h1A5`; following cycle `regWrite=0`.
- Contention with RR: `req0` and `req1` held high for 4 cycles, `addr0=1`, `addr1=6` →
  - grants are 0,1,0,1;
  - `decOut` sequence is 8'h02, 8'h40, 8'h02, 8'h40, each one cycle after its grant.
- `hold`: both requesting, `hold=1` for 3 cycles → no grants, `regWrite=0`, `prio` unchanged; first grant after `hold` drops goes to the requester that had priority before.
- Same address: `addr0=addr1=5`, `data0=9'h0F0`, `data1=9'h10F`, both requesting → two consecutive writes with `decOut=8'h20`; final data is that of the second grant.
- Reset mid-operation: assert `reset` on the edge where `req1` is accepted → no `regWrite` pulse follows; `prio=0` afterwards. Without `WRSCHED_RR_EN`, continuous `req0` → `gnt1` never asserts.
